pipe_stage_buf: RTL

//  - Generic inter-stage pipeline register with valid/ready handshake and 2-entry skid buffer.
//  - Replaces the fixed-field E/M-style stage registers. The payload is an opaque DATA_W vector (PC, instr, operands, flags concatenated by the caller).
//  - Adds back-pressure without a combinational ready path, a flush that inserts a FLUSH_VAL bubble, and an occupancy report.
//  - Sits between any two pipeline stages. The hazard unit drives flush; the downstream stage drives out_ready.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_sat_counter.sv | 36 +++
 rtl/pipe_stage_buf.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage buffers.
//  - State encoding of the stage buffer FSM; the encoding doubles as the
//    occupancy count (number of held beats).
//  - Field widths and bit offsets of the default payload concatenation
//    {pc, instr, rt_data, c, b_jump}. The b_jump field sits at bit 0.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int PC_W      = 32;
    localparam int INSTR_W   = 32;
    localparam int RT_DATA_W = 32;
    localparam int C_W       = 32;
    localparam int BJUMP_W   = 1;

    localparam int BJUMP_OFF   = 0;
    localparam int C_OFF       = BJUMP_OFF + BJUMP_W;
    localparam int RT_DATA_OFF = C_OFF + C_W;
    localparam int INSTR_OFF   = RT_DATA_OFF + RT_DATA_W;
    localparam int PC_OFF      = INSTR_OFF + INSTR_W;

    localparam int PIPE_DATA_W = PC_OFF + PC_W;  // 129

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating event counter.
//  Ports:
//   clk   in  rising-edge clock
//   reset in  synchronous active-high clear
//   inc   in  count one event this cycle
//   cnt   out current count; sticks at 2**CNT_W-1 instead of wrapping
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline register with valid/ready handshake
// and a 2-entry skid buffer (main entry + skid entry).
//  Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flush                 drop every held beat; the beat offered this cycle too
//   in_valid/in_ready     upstream handshake; in_ready is a flop
//   in_data               upstream payload (opaque DATA_W vector)
//   out_valid/out_ready   downstream handshake
//   out_data              main-entry payload, FLUSH_VAL whenever empty
//   occupancy             held beats 0..2 (the state encoding itself)
//   stall_cnt, flush_cnt  saturating statistics, present only when the
//                         macro PIPE_STATS_EN is defined
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STATS_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic [1:0]        occupancy
);

    logic [1:0]        state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;
    logic              push;
    logic              pop;

    // in_ready comes straight from a flop so out_ready never reaches it
    // combinationally; it is recomputed alongside every state change.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q    <= ST_EMPTY;
            main_q     <= FLUSH_VAL;
            skid_q     <= FLUSH_VAL;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_q <= ST_ONE;
                        main_q  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_q <= in_data;
                    end else if (push) begin
                        state_q    <= ST_TWO;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q <= ST_EMPTY;
                        main_q  <= FLUSH_VAL;
                    end
                end
                ST_TWO: begin
                    // in_ready_q is low here, so only a pop can happen.
                    if (pop) begin
                        state_q    <= ST_ONE;
                        main_q     <= skid_q;
                        skid_q     <= FLUSH_VAL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    main_q     <= FLUSH_VAL;
                    skid_q     <= FLUSH_VAL;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("pipe_stage_buf: CNT_W must be at least 1");
    end

`ifdef PIPE_STATS_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .cnt   (stall_cnt)
    );

    // reset has priority, so a flush during reset is not counted.
    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush & ~reset),
        .cnt   (flush_cnt)
    );
`endif

endmodule
